ssc_bank: RTL and testbench

- Parametrised, register-mapped bank of NCH spread-spectrum code detectors.
- All channels share one 1-bit-quantised ADC sample window. A single time-multiplexed correlator scans the channels one per cycle after each accepted sample.
- Each channel has a programmable code and threshold, last/peak score registers and a sticky code-seen flag.
- Sits on the same addr/Wdata/write/read bus and ADC/pushADC stream as the existing per-channel analysers. Adds masking, interrupt, overrun accounting and peak tracking.

---
 rtl/ssc_bank_if.sv | 22 ++
 rtl/ssc_bank.sv | 171 +++++++++++++++++
 tb/tb_ssc_bank.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ssc_bank_if.sv
// Bus and sample-stream bundle for the spread-spectrum detector bank.
// The slave modport is the bank's view; master is the host/ADC side.
interface ssc_bank_if #(
    parameter int NCH   = 32,
    parameter int ADC_W = 16
);
    logic [31:0]      addr;
    logic [31:0]      Wdata;
    logic             write;
    logic             read;
    logic [31:0]      Rdata;
    logic [ADC_W-1:0] ADC;
    logic             pushADC;
    logic [NCH-1:0]   cseen;
    logic             irq;
    logic             busy;

    modport slave  (input addr, Wdata, write, read, ADC, pushADC,
                    output Rdata, cseen, irq, busy);
    modport master (output addr, Wdata, write, read, ADC, pushADC,
                    input Rdata, cseen, irq, busy);
endinterface

// File: rtl/ssc_bank.sv
// Bank of NCH code detectors sharing one 1-bit sample window; a single
// correlator visits one channel per cycle after each accepted sample.
module ssc_bank #(
    parameter int          NCH       = 32,
    parameter int          CODE_LEN  = 32,
    parameter int          ADC_W     = 16,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input logic        clk,
    input logic        rst,
    ssc_bank_if.slave  bus
);
    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic {IDLE, SCAN} state_t;

    state_t              r_state;
    logic [CHW-1:0]      r_ch;
    logic                r_en, r_busy, r_irq;
    logic [CODE_LEN-1:0] r_win;
    logic [5:0]          r_fill;
    logic [15:0]         r_ovr;
    logic [NCH-1:0]      r_cseen, r_mask;
    logic [CODE_LEN-1:0] r_code [NCH];
    logic [5:0]          r_thr  [NCH];
    logic [5:0]          r_last [NCH];
    logic [5:0]          r_peak [NCH];
    logic [31:0]         r_rdata;

    logic [31:0]         w_off, w_wa, w_coff, w_rd;
    logic                w_in_ch;
    logic [CHW-1:0]      w_k;
    logic [1:0]          w_sub;
    logic                w_scan, w_acc, w_drop, w_hit, w_clr;
    logic                w_wr_ctrl, w_wr_ovr, w_wr_cseen, w_wr_mask, w_wr_ch;
    logic [CODE_LEN-1:0] w_xn;
    logic [5:0]          w_score;
    logic [NCH-1:0]      w_set, w_pclr, w_upd, w_wcode, w_wthr;
    logic                w_unused;

    assign w_off   = bus.addr - BASE_ADDR;
    assign w_wa    = {w_off[31:2], 2'b00};
    assign w_coff  = w_wa - 32'h100;
    assign w_in_ch = (w_wa >= 32'h100) && (w_wa < 32'h100 + 32'(16 * NCH));
    assign w_k     = w_coff[CHW+3:4];
    assign w_sub   = w_wa[3:2];

    assign w_wr_ctrl  = bus.write && (w_wa == 32'h000);
    assign w_wr_ovr   = bus.write && (w_wa == 32'h008);
    assign w_wr_cseen = bus.write && (w_wa == 32'h00C);
    assign w_wr_mask  = bus.write && (w_wa == 32'h010);
    assign w_wr_ch    = bus.write && w_in_ch;
    assign w_clr      = w_wr_ctrl && bus.Wdata[1];

    assign w_scan = (r_state == SCAN);
    assign w_acc  = bus.pushADC && r_en && (r_state == IDLE);
    assign w_drop = bus.pushADC && r_en && w_scan;

    always_comb begin
        w_xn    = ~(r_win ^ r_code[r_ch]);
        w_score = '0;
        for (int i = 0; i < CODE_LEN; i++) w_score = w_score + 6'(w_xn[i]);
    end

    // Detection is suppressed until the window holds a full code length.
    assign w_hit = w_scan && (r_fill == 6'(CODE_LEN)) && (r_thr[r_ch] != 6'd0)
                   && (w_score >= r_thr[r_ch]);

    always_comb begin
        w_set   = '0;
        w_pclr  = '0;
        w_upd   = '0;
        w_wcode = '0;
        w_wthr  = '0;
        if (w_hit) w_set[r_ch] = 1'b1;
        for (int k = 0; k < NCH; k++) begin
            w_pclr[k]  = w_clr || (w_wr_ch && w_sub == 2'd3 && w_k == CHW'(k));
            w_upd[k]   = w_scan && (r_ch == CHW'(k));
            w_wcode[k] = w_wr_ch && w_sub == 2'd0 && w_k == CHW'(k);
            w_wthr[k]  = w_wr_ch && w_sub == 2'd1 && w_k == CHW'(k);
        end
    end

    always_comb begin
        w_rd = '0;
        case (w_wa)
            32'h000: w_rd = {31'b0, r_en};
            32'h004: w_rd = {18'b0, r_fill, 7'b0, r_busy};
            32'h008: w_rd = {16'b0, r_ovr};
            32'h00C: w_rd = 32'(r_cseen);
            32'h010: w_rd = 32'(r_mask);
            default: if (w_in_ch) begin
                case (w_sub)
                    2'd0:    w_rd = 32'(r_code[w_k]);
                    2'd1:    w_rd = 32'(r_thr[w_k]);
                    2'd2:    w_rd = 32'(r_last[w_k]);
                    default: w_rd = 32'(r_peak[w_k]);
                endcase
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_ch    <= '0;
            r_en    <= 1'b0;
            r_busy  <= 1'b0;
            r_irq   <= 1'b0;
            r_win   <= '0;
            r_fill  <= '0;
            r_ovr   <= '0;
            r_cseen <= '0;
            r_mask  <= '0;
            r_rdata <= '0;
            for (int k = 0; k < NCH; k++) begin
                r_code[k] <= '0;
                r_thr[k]  <= '0;
                r_last[k] <= '0;
                r_peak[k] <= '0;
            end
        end else begin
            if (bus.read)  r_rdata <= w_rd;
            if (w_wr_ctrl) r_en    <= bus.Wdata[0];
            if (w_wr_mask) r_mask  <= bus.Wdata[NCH-1:0];

            if (w_wr_ovr)                          r_ovr <= '0;
            else if (w_drop && r_ovr != 16'hFFFF)  r_ovr <= r_ovr + 16'd1;

            // A hit in the same cycle as a software clear must survive.
            r_cseen <= (r_cseen & ~(w_wr_cseen ? bus.Wdata[NCH-1:0] : '0)
                        & ~{NCH{w_clr}}) | w_set;
            r_irq   <= |(r_cseen & r_mask);

            for (int k = 0; k < NCH; k++) begin
                if (w_wcode[k]) r_code[k] <= bus.Wdata[CODE_LEN-1:0];
                if (w_wthr[k])  r_thr[k]  <= bus.Wdata[5:0];
                if (w_upd[k]) begin
                    r_last[k] <= w_score;
                    r_peak[k] <= (w_pclr[k] || w_score > r_peak[k]) ? w_score : r_peak[k];
                end else if (w_pclr[k]) begin
                    r_peak[k] <= '0;
                end
            end

            case (r_state)
                IDLE: if (w_acc) begin
                    r_win   <= {r_win[CODE_LEN-2:0], ~bus.ADC[ADC_W-1]};
                    if (r_fill != 6'(CODE_LEN)) r_fill <= r_fill + 6'd1;
                    r_ch    <= '0;
                    r_state <= SCAN;
                    r_busy  <= 1'b1;
                end
                SCAN: if (r_ch == CHW'(NCH - 1)) begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end else begin
                    r_ch <= r_ch + CHW'(1);
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.Rdata = r_rdata;
    assign bus.cseen = r_cseen;
    assign bus.irq   = r_irq;
    assign bus.busy  = r_busy;

    assign w_unused = ^{bus.ADC, bus.addr, bus.Wdata, w_off, w_coff};
endmodule

// File: tb/tb_ssc_bank.sv
// Directed bench for ssc_bank: a transaction-level model is stepped every
// clock and all outputs are compared on the falling edge.
module tb_ssc_bank;
    localparam int NCH = 32;
    localparam int CL  = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    ssc_bank_if #(.NCH(NCH), .ADC_W(16)) bus ();
    ssc_bank #(.NCH(NCH), .CODE_LEN(CL), .ADC_W(16), .BASE_ADDR(32'h0))
        dut (.clk(clk), .rst(rst), .bus(bus));

    int errs = 0, checks = 0, cyc = 0;

    bit          m_en, m_irq;
    logic [31:0] m_mask, m_cseen, m_win, m_rdata;
    int          m_fill, m_ovr, m_t0;
    logic [31:0] m_code [NCH];
    int          m_thr [NCH], m_last [NCH], m_peak [NCH];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_en = 0; m_irq = 0; m_mask = 0; m_cseen = 0; m_win = 0; m_rdata = 0;
        m_fill = 0; m_ovr = 0; m_t0 = -1000;
        for (int k = 0; k < NCH; k++) begin
            m_code[k] = 0; m_thr[k] = 0; m_last[k] = 0; m_peak[k] = 0;
        end
    endtask

    function automatic logic [31:0] mread(input logic [31:0] a, input bit scanning);
        logic [31:0] w;
        int j;
        w = {a[31:2], 2'b00};
        if (w == 32'h000) return 32'(m_en);
        if (w == 32'h004) return 32'(m_fill * 256) | 32'(scanning);
        if (w == 32'h008) return 32'(m_ovr);
        if (w == 32'h00C) return m_cseen;
        if (w == 32'h010) return m_mask;
        if (w >= 32'h100 && w < 32'h100 + 16 * NCH) begin
            j = int'((w - 32'h100) / 16);
            case (int'((w % 16) / 4))
                0: return m_code[j];
                1: return 32'(m_thr[j]);
                2: return 32'(m_last[j]);
                default: return 32'(m_peak[j]);
            endcase
        end
        return 32'h0;
    endfunction

    // One clock of the bank as seen from the register map.
    task automatic step();
        int d, k, sc, j;
        bit scanning, hit;
        logic [31:0] w;
        d = cyc - m_t0;
        scanning = (d >= 1) && (d <= NCH);
        k = d - 1; sc = 0; hit = 0;
        w = {bus.addr[31:2], 2'b00};
        if (bus.read) m_rdata = mread(bus.addr, scanning);
        m_irq = |(m_cseen & m_mask);
        if (scanning) begin
            sc  = $countones(~(m_win ^ m_code[k]));
            hit = (m_fill == CL) && (m_thr[k] != 0) && (sc >= m_thr[k]);
        end
        if (bus.pushADC && m_en) begin
            if (scanning) begin
                if (m_ovr < 65535) m_ovr++;
            end else begin
                m_win = {m_win[30:0], ~bus.ADC[15]};
                if (m_fill < CL) m_fill++;
                m_t0 = cyc;
            end
        end
        if (bus.write) begin
            if (w == 32'h000) begin
                m_en = bus.Wdata[0];
                if (bus.Wdata[1]) begin
                    m_cseen = 0;
                    for (int i = 0; i < NCH; i++) m_peak[i] = 0;
                end
            end
            if (w == 32'h008) m_ovr = 0;
            if (w == 32'h00C) m_cseen = m_cseen & ~bus.Wdata;
            if (w == 32'h010) m_mask = bus.Wdata;
            if (w >= 32'h100 && w < 32'h100 + 16 * NCH) begin
                j = int'((w - 32'h100) / 16);
                case (int'((w % 16) / 4))
                    0: m_code[j] = bus.Wdata;
                    1: m_thr[j]  = int'(bus.Wdata[5:0]);
                    3: m_peak[j] = 0;
                    default: ;
                endcase
            end
        end
        if (scanning) begin
            m_last[k] = sc;
            if (sc > m_peak[k]) m_peak[k] = sc;
            if (hit) m_cseen[k] = 1'b1;
        end
    endtask

    task automatic tick();
        int d;
        @(posedge clk);
        cyc++;
        if (rst) step(); else model_reset();
        @(negedge clk);
        d = cyc - m_t0;
        chk("rdata", bus.Rdata, m_rdata);
        chk("cseen", bus.cseen, m_cseen);
        chk("irq",   32'(bus.irq), 32'(m_irq));
        chk("busy",  32'(bus.busy), 32'((d >= 0) && (d <= NCH - 1)));
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic do_wr(input logic [31:0] a, input logic [31:0] d);
        bus.addr = a; bus.Wdata = d; bus.write = 1'b1;
        tick();
        bus.write = 1'b0;
    endtask

    task automatic do_rd(input logic [31:0] a);
        bus.addr = a; bus.read = 1'b1;
        tick();
        bus.read = 1'b0;
    endtask

    task automatic push(input logic [15:0] v);
        bus.ADC = v; bus.pushADC = 1'b1;
        tick();
        bus.pushADC = 1'b0;
    endtask

    initial begin
        bus.addr = 0; bus.Wdata = 0; bus.write = 0; bus.read = 0;
        bus.ADC = 0; bus.pushADC = 0;
        model_reset();
        idle(2);
        rst = 1'b1;
        idle(1);
        chk("reset_busy", 32'(bus.busy), 32'h0);

        // Reset asserted in the middle of a scan
        do_wr(32'h150, 32'hA5A5_A5A5);
        do_rd(32'h150);
        chk("code5_rd", bus.Rdata, 32'hA5A5_A5A5);
        do_wr(32'h000, 32'h1);
        push(16'h0100);
        idle(2);
        chk("busy_mid_scan", 32'(bus.busy), 32'h1);
        #2 rst = 1'b0;
        #1;
        chk("rst_async_cseen", bus.cseen, 32'h0);
        chk("rst_async_irq",   32'(bus.irq), 32'h0);
        chk("rst_async_busy",  32'(bus.busy), 32'h0);
        chk("rst_async_rdata", bus.Rdata, 32'h0);
        model_reset();
        idle(2);
        rst = 1'b1;
        do_rd(32'h100);
        chk("code0_after_rst", bus.Rdata, 32'h0);
        do_rd(32'h150);
        chk("code5_after_rst", bus.Rdata, 32'h0);

        // Bus basics
        do_wr(32'h150, 32'hA5A5_A5A5);
        do_rd(32'h150);
        chk("code5_wr_rd", bus.Rdata, 32'hA5A5_A5A5);
        do_rd(32'h0FC);
        chk("unmapped_rd", bus.Rdata, 32'h0);

        // Detection on channel 0
        do_wr(32'h100, 32'hFFFF_FFFF);
        do_wr(32'h104, 32'd32);
        do_wr(32'h010, 32'h1);
        do_wr(32'h000, 32'h1);
        for (int i = 0; i < 31; i++) begin
            push(16'h0100);
            idle(NCH);
        end
        chk("cseen0_before_full", 32'(bus.cseen[0]), 32'h0);
        push(16'h0100);
        tick();
        chk("cseen0_T1", 32'(bus.cseen[0]), 32'h1);
        chk("irq_T1", 32'(bus.irq), 32'h0);
        tick();
        chk("irq_T2", 32'(bus.irq), 32'h1);
        idle(NCH);
        do_rd(32'h108);
        chk("last0", bus.Rdata, 32'd32);
        do_rd(32'h10C);
        chk("peak0", bus.Rdata, 32'd32);

        // Anti-correlation on channel 1 (code 0)
        do_wr(32'h000, 32'h3);
        push(16'h0100);
        idle(NCH);
        do_rd(32'h118);
        chk("last1_ones", bus.Rdata, 32'd0);
        do_rd(32'h11C);
        chk("peak1_ones", bus.Rdata, 32'd0);
        chk("cseen1_ones", 32'(bus.cseen[1]), 32'h0);
        for (int i = 0; i < 32; i++) begin
            push(16'h8000);
            idle(NCH);
        end
        do_rd(32'h118);
        chk("last1_zeros", bus.Rdata, 32'd32);
        do_rd(32'h11C);
        chk("peak1_zeros", bus.Rdata, 32'd32);
        chk("thresh0_no_detect", 32'(bus.cseen[1]), 32'h0);

        // Software clear racing a hit on channel 0
        do_wr(32'h100, 32'h0);
        do_wr(32'h00C, 32'h1);
        chk("cseen0_w1c", 32'(bus.cseen[0]), 32'h0);
        push(16'h8000);
        bus.addr = 32'h00C; bus.Wdata = 32'h1; bus.write = 1'b1;
        tick();
        bus.write = 1'b0;
        chk("race_set_wins", 32'(bus.cseen[0]), 32'h1);
        idle(NCH);

        // Overrun
        push(16'h0100);
        idle(2);
        push(16'h0100);
        idle(NCH);
        do_rd(32'h008);
        chk("ovr_one", bus.Rdata, 32'd1);
        do_rd(32'h108);
        chk("window_shift_once", bus.Rdata, 32'd31);
        do_rd(32'h004);
        chk("status_fill", bus.Rdata, 32'h0000_2000);
        bus.ADC = 16'h0100; bus.pushADC = 1'b1;
        idle(70000);
        bus.pushADC = 1'b0;
        idle(NCH + 1);
        do_rd(32'h008);
        chk("ovr_sat", bus.Rdata, 32'h0000_FFFF);
        do_wr(32'h008, 32'h0);
        do_rd(32'h008);
        chk("ovr_clear", bus.Rdata, 32'h0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
